// File: rtl/peripheral_adder_arb_pkg.sv
// Shared types and constants for the peripheral adder arbiter.
// Optional result checker is enabled by defining PERIPHERAL_ADDER_ARB_CHECK_EN.
package peripheral_adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ADDER_LAT = 0;

    // Index width for n items, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/peripheral_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module peripheral_rr_picker
    import peripheral_adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/peripheral_adder_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ requesters.
// Each operation runs IDLE -> ISSUE (ADDER_LAT+1 cycles) -> RESP.
// Define PERIPHERAL_ADDER_ARB_CHECK_EN to enable the sticky result checker (chk_err).
module peripheral_adder_arbiter
    import peripheral_adder_arb_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int ADDER_LAT = DEF_ADDER_LAT,
    localparam int IW        = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    input  logic [NUM_REQ*DATA_W-1:0] req_y,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IW-1:0]             rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_cout,
    output logic [DATA_W-1:0]         add_x,
    output logic [DATA_W-1:0]         add_y,
    output logic                      add_cin,
    input  logic [DATA_W-1:0]         add_sum,
    input  logic                      add_cout,
    output logic                      busy,
    output logic                      chk_err
);

    localparam int CW = id_w(ADDER_LAT + 1);

    arb_state_t          state, state_next;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       wait_cnt;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                accept;
    logic                capture;

    peripheral_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic plus the accept/capture strobes and the grant to requesters.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && reset) begin
                    req_ready  = pick_grant;
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, latency countdown, result capture and pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_x    <= '0;
            add_y    <= '0;
            add_cin  <= 1'b0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            wait_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            if (accept) begin
                add_x    <= req_x[pick_idx*DATA_W +: DATA_W];
                add_y    <= req_y[pick_idx*DATA_W +: DATA_W];
                add_cin  <= req_cin[pick_idx];
                rsp_id   <= pick_idx;
                wait_cnt <= CW'(ADDER_LAT);
            end else if (state == ISSUE && !capture) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
            end
            if (rsp_valid && rsp_ready) begin
                rr_ptr <= (rsp_id == IW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            end
        end
    end

`ifdef PERIPHERAL_ADDER_ARB_CHECK_EN
    logic [DATA_W:0] chk_expect;
    logic            chk_flag;

    assign chk_expect = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
    assign chk_err    = chk_flag;

    // Sticky flag set when the adder result disagrees with the local sum at capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) chk_flag <= 1'b0;
        else if (capture && ({add_cout, add_sum} != chk_expect)) chk_flag <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_adder_arbiter.sv
// Self-checking bench for peripheral_adder_arbiter: directed steps then a randomized
// phase checked against a transaction-level round-robin model.
module tb_peripheral_adder_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;

    logic [N-1:0]   req_valid, req_ready, req_cin;
    logic [N*W-1:0] req_x, req_y;
    logic           rsp_valid, rsp_ready, rsp_cout, add_cin, add_cout, busy, chk_err;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum, add_x, add_y, add_sum;
    logic           corrupt;
    logic [W:0]     sum0;

    logic [N-1:0]   l2_req_valid, l2_req_ready, l2_req_cin;
    logic [N*W-1:0] l2_req_x, l2_req_y;
    logic           l2_rsp_valid, l2_rsp_ready, l2_rsp_cout, l2_add_cin, l2_add_cout, l2_busy, l2_chk_err;
    logic [1:0]     l2_rsp_id;
    logic [W-1:0]   l2_rsp_sum, l2_add_x, l2_add_y, l2_add_sum;
    logic [W:0]     l2_s1, l2_s2;

    int errors = 0;
    int checks = 0;

    peripheral_adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADDER_LAT(0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .chk_err(chk_err)
    );

    peripheral_adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .ADDER_LAT(2)) dut_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(l2_req_valid), .req_ready(l2_req_ready),
        .req_x(l2_req_x), .req_y(l2_req_y), .req_cin(l2_req_cin),
        .rsp_valid(l2_rsp_valid), .rsp_ready(l2_rsp_ready), .rsp_id(l2_rsp_id),
        .rsp_sum(l2_rsp_sum), .rsp_cout(l2_rsp_cout),
        .add_x(l2_add_x), .add_y(l2_add_y), .add_cin(l2_add_cin),
        .add_sum(l2_add_sum), .add_cout(l2_add_cout),
        .busy(l2_busy), .chk_err(l2_chk_err)
    );

    // Zero-latency adder with an optional forced error on the sum LSB.
    assign sum0     = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    assign add_sum  = sum0[W-1:0] ^ {{(W-1){1'b0}}, corrupt};
    assign add_cout = sum0[W];

    // Two-cycle adder: result only appears two clocks after the operands settle.
    always @(posedge clk) begin
        l2_s1 <= {1'b0, l2_add_x} + {1'b0, l2_add_y} + {{W{1'b0}}, l2_add_cin};
        l2_s2 <= l2_s1;
    end
    assign l2_add_sum  = l2_s2[W-1:0];
    assign l2_add_cout = l2_s2[W];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
        req_valid = v;
        rsp_ready = rr;
        #1;
    endtask

    task automatic setOps(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_cin[i]      = c;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stepCycle();
    endtask

    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];
    logic         cs [N];

    initial begin
        int exp_id, s, ptr_m, id_m, cnt_m, win;
        bit pend_m;
        logic [N-1:0] accepted, exp_ready;
        logic [W-1:0] sum_m;
        logic cout_m, exp_rv;

        reset = 1'b0;
        corrupt = 1'b0;
        req_valid = '0; req_x = '0; req_y = '0; req_cin = '0; rsp_ready = 1'b1;
        l2_req_valid = '0; l2_req_x = '0; l2_req_y = '0; l2_req_cin = '0; l2_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    32'h0);
        checkOutput("rst_rsp_sum",   32'(rsp_sum),   32'h0);
        checkOutput("rst_rsp_cout",  32'(rsp_cout),  32'h0);
        checkOutput("rst_add_x",     32'(add_x),     32'h0);
        checkOutput("rst_add_y",     32'(add_y),     32'h0);
        checkOutput("rst_add_cin",   32'(add_cin),   32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_chk_err",   32'(chk_err),   32'h0);
        @(negedge clk);
        reset = 1'b1;
        stepCycle();

        // Single request from requester 2: 9+8+1 = 0x12
        setOps(2, 4'h9, 4'h8, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("t1_req_ready", 32'(req_ready), 32'h4);
        checkOutput("t1_busy_T",    32'(busy),      32'h0);
        stepCycle();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t1_busy_T1",   32'(busy),      32'h1);
        checkOutput("t1_add_x",     32'(add_x),     32'h9);
        checkOutput("t1_add_y",     32'(add_y),     32'h8);
        checkOutput("t1_add_cin",   32'(add_cin),   32'h1);
        checkOutput("t1_rsp_valid_T1", 32'(rsp_valid), 32'h0);
        stepCycle();
        checkOutput("t1_rsp_valid_T2", 32'(rsp_valid), 32'h1);
        checkOutput("t1_rsp_id",    32'(rsp_id),    32'h2);
        checkOutput("t1_rsp_sum",   32'(rsp_sum),   32'h2);
        checkOutput("t1_rsp_cout",  32'(rsp_cout),  32'h1);
        stepCycle();
        checkOutput("t1_idle_after", 32'(busy), 32'h0);

        // All four requesters continuously valid: ids 0,1,2,3,0 every 3 cycles
        pulseReset();
        for (int i = 0; i < N; i++) begin
            xs[i] = 4'($urandom_range(15));
            ys[i] = 4'($urandom_range(15));
            cs[i] = 1'($urandom_range(1));
            setOps(i, xs[i], ys[i], cs[i]);
        end
        applyStimulus(4'hF, 1'b1);
        for (int k = 0; k < 5; k++) begin
            exp_id = k % N;
            s = int'(xs[exp_id]) + int'(ys[exp_id]) + int'(cs[exp_id]);
            checkOutput("t2_req_ready", 32'(req_ready), 32'(1 << exp_id));
            stepCycle();
            checkOutput("t2_rsp_valid_issue", 32'(rsp_valid), 32'h0);
            stepCycle();
            checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("t2_rsp_id",    32'(rsp_id),    32'(exp_id));
            checkOutput("t2_rsp_sum",   32'(rsp_sum),   32'(s % 16));
            checkOutput("t2_rsp_cout",  32'(rsp_cout),  32'(s / 16));
            stepCycle();
        end

        // Backpressure: pointer is now 1, hold rsp_ready low in RESP
        applyStimulus(4'hF, 1'b0);
        checkOutput("t3_req_ready", 32'(req_ready), 32'h2);
        s = int'(xs[1]) + int'(ys[1]) + int'(cs[1]);
        stepCycle();
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_stall_rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("t3_stall_rsp_id",    32'(rsp_id),    32'h1);
            checkOutput("t3_stall_rsp_sum",   32'(rsp_sum),   32'(s % 16));
            checkOutput("t3_stall_req_ready", 32'(req_ready), 32'h0);
            stepCycle();
        end
        applyStimulus(4'hF, 1'b1);
        checkOutput("t3_release_rsp_valid", 32'(rsp_valid), 32'h1);
        stepCycle();
        checkOutput("t3_idle_busy",      32'(busy),      32'h0);
        checkOutput("t3_idle_req_ready", 32'(req_ready), 32'h4);
        applyStimulus(4'h0, 1'b1);

        // Latency-2 instance: F+0+1 = 0x10
        l2_req_x[3:0] = 4'hF;
        l2_req_y[3:0] = 4'h0;
        l2_req_cin[0] = 1'b1;
        l2_req_valid  = 4'b0001;
        #1;
        checkOutput("t4_req_ready", 32'(l2_req_ready), 32'h1);
        stepCycle();
        l2_req_valid = 4'b0000;
        for (int i = 1; i <= 3; i++) begin
            checkOutput("t4_add_x_stable",   32'(l2_add_x),     32'hF);
            checkOutput("t4_add_y_stable",   32'(l2_add_y),     32'h0);
            checkOutput("t4_add_cin_stable", 32'(l2_add_cin),   32'h1);
            checkOutput("t4_rsp_valid_wait", 32'(l2_rsp_valid), 32'h0);
            stepCycle();
        end
        checkOutput("t4_rsp_valid", 32'(l2_rsp_valid), 32'h1);
        checkOutput("t4_rsp_sum",   32'(l2_rsp_sum),   32'h0);
        checkOutput("t4_rsp_cout",  32'(l2_rsp_cout),  32'h1);
        stepCycle();

        // Reset asserted during ISSUE; pointer is 2 so requester 1 wins via wrap
        setOps(1, 4'h5, 4'h6, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("t5_req_ready", 32'(req_ready), 32'h2);
        stepCycle();
        applyStimulus(4'b0000, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("t5_add_x",     32'(add_x),     32'h0);
        checkOutput("t5_add_y",     32'(add_y),     32'h0);
        checkOutput("t5_add_cin",   32'(add_cin),   32'h0);
        checkOutput("t5_busy",      32'(busy),      32'h0);
        checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("t5_rsp_id",    32'(rsp_id),    32'h0);
        checkOutput("t5_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("t5_no_rsp", 32'(rsp_valid), 32'h0);
        end
        applyStimulus(4'hF, 1'b1);
        checkOutput("t5_restart_req_ready", 32'(req_ready), 32'h1);
        applyStimulus(4'h0, 1'b1);
        stepCycle();

`ifdef PERIPHERAL_ADDER_ARB_CHECK_EN
        // Corrupted adder result must raise a sticky chk_err
        corrupt = 1'b1;
        setOps(0, 4'h3, 4'h4, 1'b0);
        pulseReset();
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t6_req_ready", 32'(req_ready), 32'h1);
        stepCycle();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("t6_chk_before", 32'(chk_err), 32'h0);
        stepCycle();
        checkOutput("t6_chk_err", 32'(chk_err), 32'h1);
        checkOutput("t6_rsp_sum", 32'(rsp_sum), 32'h6);
        corrupt = 1'b0;
        repeat (3) stepCycle();
        checkOutput("t6_chk_sticky", 32'(chk_err), 32'h1);
        pulseReset();
        checkOutput("t6_chk_cleared", 32'(chk_err), 32'h0);
`else
        checkOutput("t6_chk_tied", 32'(chk_err), 32'h0);
`endif

        // Randomized traffic against a transaction-level round-robin model
        pulseReset();
        req_valid = '0;
        ptr_m = 0; pend_m = 1'b0; cnt_m = 0; id_m = 0; sum_m = '0; cout_m = 1'b0;
        accepted = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (accepted[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        setOps(i, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            if (pend_m) cnt_m++;
            exp_ready = '0;
            win = -1;
            if (!pend_m) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(ptr_m + k) % N]) win = (ptr_m + k) % N;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            exp_rv = pend_m && (cnt_m >= 2);
            checkOutput("rand_req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("rand_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                checkOutput("rand_rsp_id",   32'(rsp_id),   32'(id_m));
                checkOutput("rand_rsp_sum",  32'(rsp_sum),  32'(sum_m));
                checkOutput("rand_rsp_cout", 32'(rsp_cout), 32'(cout_m));
            end
            accepted = exp_ready;
            if (exp_rv && rsp_ready) begin
                pend_m = 1'b0;
                ptr_m  = (id_m + 1) % N;
            end else if (win >= 0) begin
                pend_m = 1'b1;
                cnt_m  = 0;
                id_m   = win;
                s      = int'(req_x[win*W +: W]) + int'(req_y[win*W +: W]) + int'(req_cin[win]);
                sum_m  = 4'(s % 16);
                cout_m = 1'(s / 16);
            end
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peripheral_adder_arbiter.md
Name: peripheral_adder_arbiter

Overview:
- Shares one DATA_W-bit ripple adder (operands x, y, cin; results sum, cout) between NUM_REQ requesters.
- Per-requester valid/ready request channels; one shared response channel tagged with requester id.
- Round-robin grant; sequences each operation as issue, wait ADDER_LAT cycles, capture, respond.
- Sits between peripheral masters and the adder datapath exercised by the peripheral UVM environment.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 4, operand/sum width.
- ADDER_LAT, 0, adder latency in clk cycles from operand drive to valid sum/cout (0 = combinational).

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  input  NUM_REQ*DATA_W  operand x, requester i at [i*DATA_W +: DATA_W].
- req_y  input  NUM_REQ*DATA_W  operand y, same packing.
- req_cin  input  NUM_REQ  carry-in per requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  $clog2(NUM_REQ)  requester index of response.
- rsp_sum  output  DATA_W  captured sum.
- rsp_cout  output  1  captured carry-out.
- add_x  output  DATA_W  to adder x.
- add_y  output  DATA_W  to adder y.
- add_cin  output  1  to adder cin.
- add_sum  input  DATA_W  from adder sum.
- add_cout  input  1  from adder cout.
- busy  output  1  high in any state other than IDLE.
- chk_err  output  1  sticky result-mismatch flag (optional feature).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, grant id=0.
  - add_x/add_y/add_cin=0; rsp_valid/rsp_id/rsp_sum/rsp_cout=0; chk_err=0; req_ready=0.
  - Reset mid-operation abandons the operation silently; no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally, only in IDLE and only when any req_valid is set.
  - On accept: latch operands into add_x/add_y/add_cin registers, latch grant id, load wait_cnt=ADDER_LAT, go to ISSUE.
- ISSUE:
  - add_* held stable.
  - If wait_cnt==0: capture add_sum/add_cout into rsp_sum/rsp_cout, go to RESP. Otherwise decrement wait_cnt.
- RESP:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_cout held stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_ptr = (id+1) mod NUM_REQ, go to IDLE.
  - add_* remain at their last values.
- Latency: accept at cycle T, rsp_valid at T+2+ADDER_LAT if capture is taken at T+1+ADDER_LAT.
- Throughput: at most 1 operation per ADDER_LAT+3 cycles; no IDLE bypass.
- Requesters hold req_valid and operands until req_ready. Dropping req_valid before grant is legal; no state is kept for that requester.
- Simultaneous requests: only the round-robin winner is accepted; losers wait. Starvation bound is NUM_REQ operations.
- Overflow: cout carries the DATA_W+1 bit; no saturation.

Optional Feature:
- Macro: PERIPHERAL_ADDER_ARB_CHECK_EN.
- Defined: at capture, compare {add_cout, add_sum} against an internal {1'b0,x}+{1'b0,y}+cin computed on the latched operands. A mismatch sets chk_err=1, sticky until reset.
- Not defined: chk_err tied 0; no checker logic.

Decomposition:
- Package peripheral_adder_arb_pkg:
  - state enum (IDLE, ISSUE, RESP).
  - default parameter constants.
  - ID_W function ($clog2 with minimum 1).
- Sub-module peripheral_rr_picker: combinational round-robin; inputs req vector and pointer, outputs one-hot grant, index and any-valid.

Test Plan:
1. Single request, ADDER_LAT=0: req 2 with x=4'h9, y=4'h8, cin=1 -> req_ready[2] at T; rsp_valid at T+2 with rsp_id=2, rsp_sum=4'h2, rsp_cout=1.
2. All four requesters valid continuously, rr_ptr=0 -> rsp_id sequence 0,1,2,3,0, each operation spaced 3 cycles with rsp_ready=1.
3. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_sum stable; req_ready stays 0 during the stall; IDLE is reached the cycle after rsp_ready=1.
4. ADDER_LAT=2, x=4'hF, y=4'h0, cin=1 -> rsp_valid at T+4, sum=4'h0, cout=1; add_* stable for 3 cycles.
5. Reset asserted in ISSUE -> all outputs 0 immediately; no response after release; next grant starts at requester 0.
6. With PERIPHERAL_ADDER_ARB_CHECK_EN, adder model forced to return sum^1 -> chk_err=1 after capture and remains 1 until reset.
